layer_sequencer: RTL and testbench

- Parametrised successor to the fixed-depth network controller.
- Sequences input buffer load, N compute layers with a per-layer optional activation pass, and the final class comparison.
- Adds start/done handshakes to each engine, a ready/valid result port, abort, a per-stage watchdog and a sticky timeout error.
- Sits at network top, between the host-side load/result interface and the cnn, activation and comparison engines.

---
 rtl/layer_sequencer_pkg.sv | 18 +
 rtl/layer_sequencer_stage_watchdog.sv | 30 +++
 rtl/layer_sequencer.sv | 171 +++++++++++++++++
 tb/tb_layer_sequencer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/layer_sequencer_pkg.sv
// Shared codes for the layer sequencer: FSM state encoding and the
// cnn input source-select values.
package layer_sequencer_pkg;

  typedef enum logic [2:0] {
    LS_IDLE  = 3'd0,
    LS_LOAD  = 3'd1,
    LS_LAYER = 3'd2,
    LS_ACT   = 3'd3,
    LS_COMP  = 3'd4,
    LS_DONE  = 3'd5
  } ls_state_t;

  localparam logic [1:0] SRC_BUF = 2'd0;
  localparam logic [1:0] SRC_ACT = 2'd1;
  localparam logic [1:0] SRC_CNN = 2'd2;

endpackage

// File: rtl/layer_sequencer_stage_watchdog.sv
// Per-stage wait counter. It is cleared when a stage is entered, counts while
// the engine is being waited on, and flags expiry once TIMEOUT cycles have
// been spent in the stage. TIMEOUT=0 disables expiry.
module stage_watchdog #(
  parameter int TIMEOUT = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [CNT_W-1:0] cnt;

  // Count wait cycles, holding at the limit so the counter never wraps.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en && (cnt != LIMIT)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (TIMEOUT != 0) && en && (cnt == LIMIT);

endmodule

// File: rtl/layer_sequencer.sv
// Network-level sequencer: input buffer load, NUM_LAYERS cnn passes with an
// optional activation pass per layer, then the class comparison. Each engine
// gets a start pulse and is waited on under a per-stage watchdog.
module layer_sequencer
  import layer_sequencer_pkg::*;
#(
  parameter int                    NUM_LAYERS = 5,
  parameter logic [NUM_LAYERS-1:0] ACT_MASK   = {NUM_LAYERS{1'b1}},
  parameter int                    TIMEOUT    = 1023,
  parameter int                    CLASS_W    = 4,
  parameter int                    LIDX_W     = $clog2(NUM_LAYERS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  output logic               buf_load,
  output logic               cnn_start,
  output logic [LIDX_W-1:0]  cnn_layer,
  output logic [1:0]         cnn_src_sel,
  input  logic               cnn_done,
  output logic               act_start,
  input  logic               act_done,
  output logic               comp_start,
  output logic               comp_src_sel,
  input  logic               comp_done,
  input  logic [CLASS_W-1:0] comp_class,
  output logic               out_valid,
  output logic [CLASS_W-1:0] out_class,
  input  logic               out_ready,
  output logic               busy,
  output logic               err_timeout
);

  ls_state_t          state, state_nxt;
  logic               first;
  logic               enter;
  logic [LIDX_W-1:0]  layer_idx, layer_nxt, prev_idx;
  logic               last_layer;
  logic               expired;
  logic               err_set, err_clr, cap;
  logic               wait_st;

  assign last_layer = (layer_idx == LIDX_W'(NUM_LAYERS - 1));
  assign prev_idx   = layer_idx - 1'b1;
  assign wait_st    = (state == LS_LAYER) || (state == LS_ACT) || (state == LS_COMP);

  stage_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (enter),
    .en      (wait_st),
    .expired (expired)
  );

  // Next-state, layer advance and flag control; abort overrides everything.
  always_comb begin
    state_nxt = state;
    layer_nxt = layer_idx;
    enter     = 1'b0;
    err_set   = 1'b0;
    err_clr   = 1'b0;
    cap       = 1'b0;
    case (state)
      LS_IDLE: begin
        if (start) begin
          state_nxt = LS_LOAD;
          err_clr   = 1'b1;
        end
      end
      LS_LOAD: begin
        state_nxt = LS_LAYER;
        layer_nxt = '0;
        enter     = 1'b1;
      end
      LS_LAYER: begin
        if (!first && cnn_done) begin
          enter = 1'b1;
          if (ACT_MASK[layer_idx]) begin
            state_nxt = LS_ACT;
          end else if (!last_layer) begin
            state_nxt = LS_LAYER;
            layer_nxt = layer_idx + 1'b1;
          end else begin
            state_nxt = LS_COMP;
          end
        end else if (expired) begin
          state_nxt = LS_IDLE;
          err_set   = 1'b1;
        end
      end
      LS_ACT: begin
        if (act_done) begin
          enter = 1'b1;
          if (!last_layer) begin
            state_nxt = LS_LAYER;
            layer_nxt = layer_idx + 1'b1;
          end else begin
            state_nxt = LS_COMP;
          end
        end else if (expired) begin
          state_nxt = LS_IDLE;
          err_set   = 1'b1;
        end
      end
      LS_COMP: begin
        if (comp_done) begin
          state_nxt = LS_DONE;
          cap       = 1'b1;
        end else if (expired) begin
          state_nxt = LS_IDLE;
          err_set   = 1'b1;
        end
      end
      LS_DONE: begin
        if (out_ready) begin
          if (start) begin
            state_nxt = LS_LOAD;
            err_clr   = 1'b1;
          end else begin
            state_nxt = LS_IDLE;
          end
        end
      end
      default: state_nxt = LS_IDLE;
    endcase
    if (abort) begin
      state_nxt = LS_IDLE;
      layer_nxt = layer_idx;
      enter     = 1'b0;
      err_set   = 1'b0;
      err_clr   = 1'b0;
      cap       = 1'b0;
    end
  end

  // State, first-cycle marker, layer index, sticky error and result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= LS_IDLE;
      first       <= 1'b0;
      layer_idx   <= '0;
      err_timeout <= 1'b0;
      out_class   <= '0;
    end else begin
      state     <= state_nxt;
      first     <= enter;
      layer_idx <= layer_nxt;
      if (err_clr) begin
        err_timeout <= 1'b0;
      end else if (err_set) begin
        err_timeout <= 1'b1;
      end
      if (cap) begin
        out_class <= comp_class;
      end
    end
  end

  assign buf_load     = (state == LS_LOAD);
  assign cnn_start    = (state == LS_LAYER) && first;
  assign act_start    = (state == LS_ACT) && first;
  assign comp_start   = (state == LS_COMP) && first;
  assign out_valid    = (state == LS_DONE);
  assign busy         = (state != LS_IDLE);
  assign cnn_layer    = layer_idx;
  assign cnn_src_sel  = (layer_idx == '0) ? SRC_BUF :
                        (ACT_MASK[prev_idx] ? SRC_ACT : SRC_CNN);
  assign comp_src_sel = ACT_MASK[NUM_LAYERS-1];

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer using three configurations:
// A: 2 layers, mask 01; B: 5 layers, all activations, short watchdog;
// C: 5 layers, no activations, reset applied mid-run.
module tb_layer_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic rst, rst_c;

  // Instance A signals
  logic start_a, abort_a, cnn_done_a, act_done_a, comp_done_a, out_ready_a;
  logic [3:0] comp_class_a, out_class_a;
  logic buf_load_a, cnn_start_a, act_start_a, comp_start_a, comp_src_sel_a;
  logic out_valid_a, busy_a, err_a;
  logic [0:0] cnn_layer_a;
  logic [1:0] cnn_src_sel_a;
  logic pc_a, pa_a, pm_a;

  // Instance B signals
  logic start_b, abort_b, cnn_done_b, act_done_b, comp_done_b, out_ready_b;
  logic [3:0] comp_class_b, out_class_b;
  logic buf_load_b, cnn_start_b, act_start_b, comp_start_b, comp_src_sel_b;
  logic out_valid_b, busy_b, err_b;
  logic [2:0] cnn_layer_b;
  logic [1:0] cnn_src_sel_b;
  logic pc_b, pa_b, pm_b, blk_b, poke_b;

  // Instance C signals
  logic start_c, abort_c, cnn_done_c, act_done_c, comp_done_c, out_ready_c;
  logic [3:0] comp_class_c, out_class_c;
  logic buf_load_c, cnn_start_c, act_start_c, comp_start_c, comp_src_sel_c;
  logic out_valid_c, busy_c, err_c;
  logic [2:0] cnn_layer_c;
  logic [1:0] cnn_src_sel_c;
  logic pc_c, pa_c, pm_c;

  layer_sequencer #(.NUM_LAYERS(2), .ACT_MASK(2'b01), .TIMEOUT(8)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a),
    .buf_load(buf_load_a), .cnn_start(cnn_start_a), .cnn_layer(cnn_layer_a),
    .cnn_src_sel(cnn_src_sel_a), .cnn_done(cnn_done_a), .act_start(act_start_a),
    .act_done(act_done_a), .comp_start(comp_start_a), .comp_src_sel(comp_src_sel_a),
    .comp_done(comp_done_a), .comp_class(comp_class_a), .out_valid(out_valid_a),
    .out_class(out_class_a), .out_ready(out_ready_a), .busy(busy_a),
    .err_timeout(err_a));

  layer_sequencer #(.TIMEOUT(8)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b),
    .buf_load(buf_load_b), .cnn_start(cnn_start_b), .cnn_layer(cnn_layer_b),
    .cnn_src_sel(cnn_src_sel_b), .cnn_done(cnn_done_b), .act_start(act_start_b),
    .act_done(act_done_b), .comp_start(comp_start_b), .comp_src_sel(comp_src_sel_b),
    .comp_done(comp_done_b), .comp_class(comp_class_b), .out_valid(out_valid_b),
    .out_class(out_class_b), .out_ready(out_ready_b), .busy(busy_b),
    .err_timeout(err_b));

  layer_sequencer #(.ACT_MASK(5'b00000)) dut_c (
    .clk(clk), .rst(rst || rst_c), .start(start_c), .abort(abort_c),
    .buf_load(buf_load_c), .cnn_start(cnn_start_c), .cnn_layer(cnn_layer_c),
    .cnn_src_sel(cnn_src_sel_c), .cnn_done(cnn_done_c), .act_start(act_start_c),
    .act_done(act_done_c), .comp_start(comp_start_c), .comp_src_sel(comp_src_sel_c),
    .comp_done(comp_done_c), .comp_class(comp_class_c), .out_valid(out_valid_c),
    .out_class(out_class_c), .out_ready(out_ready_c), .busy(busy_c),
    .err_timeout(err_c));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge; engines answer one cycle after each start.
  task automatic tick();
    @(negedge clk);
    comp_class_a = pm_a ? 4'd7 : 4'd0;
    cnn_done_a = pc_a; pc_a = cnn_start_a;
    act_done_a = pa_a; pa_a = act_start_a;
    comp_done_a = pm_a; pm_a = comp_start_a;
    comp_class_b = pm_b ? 4'd7 : 4'd0;
    cnn_done_b = pc_b; pc_b = cnn_start_b && !(blk_b && (cnn_layer_b == 3'd2));
    act_done_b = pa_b | poke_b; pa_b = act_start_b;
    comp_done_b = pm_b; pm_b = comp_start_b;
    comp_class_c = pm_c ? 4'd7 : 4'd0;
    cnn_done_c = pc_c; pc_c = cnn_start_c;
    act_done_c = pa_c; pa_c = act_start_c;
    comp_done_c = pm_c; pm_c = comp_start_c;
  endtask

  logic [4:0] exp1 [1:10];
  int lat, found, act_seen, lyr_cnt;

  initial begin
    exp1[1] = 5'b10000; exp1[2] = 5'b01000; exp1[3] = 5'b00000; exp1[4] = 5'b00100;
    exp1[5] = 5'b00000; exp1[6] = 5'b01000; exp1[7] = 5'b00000; exp1[8] = 5'b00010;
    exp1[9] = 5'b00000; exp1[10] = 5'b00001;
    rst = 1'b1; rst_c = 1'b0;
    {start_a, abort_a, cnn_done_a, act_done_a, comp_done_a, out_ready_a, pc_a, pa_a, pm_a} = '0;
    {start_b, abort_b, cnn_done_b, act_done_b, comp_done_b, out_ready_b, pc_b, pa_b, pm_b} = '0;
    {start_c, abort_c, cnn_done_c, act_done_c, comp_done_c, out_ready_c, pc_c, pa_c, pm_c} = '0;
    blk_b = 1'b0; poke_b = 1'b0;
    comp_class_a = '0; comp_class_b = '0; comp_class_c = '0;
    repeat (3) tick();

    // Reset state
    chk("rst_a_outs", 32'({buf_load_a, cnn_start_a, act_start_a, comp_start_a,
        out_valid_a, busy_a, err_a, out_class_a, cnn_layer_a, cnn_src_sel_a}), 32'd0);
    chk("rst_b_outs", 32'({buf_load_b, cnn_start_b, act_start_b, comp_start_b,
        out_valid_b, busy_b, err_b, out_class_b}), 32'd0);
    rst = 1'b0;
    tick();
    chk("idle_a_busy", 32'(busy_a), 32'd0);

    // A: cycle-exact two-layer run
    start_a = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      start_a = 1'b0;
      chk($sformatf("a_strobes_c%0d", c),
          32'({buf_load_a, cnn_start_a, act_start_a, comp_start_a, out_valid_a}), 32'(exp1[c]));
      case (c)
        2: chk("a_l0_idx_sel", 32'({cnn_layer_a, cnn_src_sel_a}), 32'({1'b0, 2'd0}));
        3: chk("a_l0_idx_held", 32'(cnn_layer_a), 32'd0);
        6: chk("a_l1_idx_sel", 32'({cnn_layer_a, cnn_src_sel_a}), 32'({1'b1, 2'd1}));
        8: chk("a_comp_src", 32'(comp_src_sel_a), 32'd0);
        10: chk("a_out_class", 32'(out_class_a), 32'd7);
        default: ;
      endcase
    end
    out_ready_a = 1'b1;
    tick();
    out_ready_a = 1'b0;
    chk("a_ack_idle", 32'({busy_a, out_valid_a}), 32'd0);

    // B: full-activation run, latency and result stall
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    lat = 1;
    while (!out_valid_b && lat < 60) begin
      tick();
      lat++;
    end
    chk("b_latency", 32'(lat), 32'd24);
    for (int i = 0; i < 20; i++) begin
      start_b = (i == 5);
      tick();
      chk($sformatf("b_stall_%0d", i), 32'({out_valid_b, buf_load_b, out_class_b}),
          32'({1'b1, 1'b0, 4'd7}));
    end
    start_b = 1'b0;
    out_ready_b = 1'b1; start_b = 1'b1;
    tick();
    out_ready_b = 1'b0; start_b = 1'b0;
    chk("b_b2b_load", 32'({buf_load_b, out_valid_b}), 32'({1'b1, 1'b0}));

    // B: watchdog expiry with layer 2 never answering
    blk_b = 1'b1;
    found = 0;
    for (int i = 0; i < 60 && found == 0; i++) begin
      tick();
      if (cnn_start_b && cnn_layer_b == 3'd2) found = 1;
    end
    chk("b_found_l2", 32'(found), 32'd1);
    repeat (7) tick();
    chk("b_wd_pre", 32'({busy_b, err_b}), 32'({1'b1, 1'b0}));
    tick();
    chk("b_wd_expire", 32'({busy_b, err_b, out_valid_b}), 32'({1'b0, 1'b1, 1'b0}));
    abort_b = 1'b1;
    tick();
    abort_b = 1'b0;
    chk("b_err_keep_abort", 32'({err_b, busy_b}), 32'({1'b1, 1'b0}));
    blk_b = 1'b0;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    chk("b_err_clr_start", 32'({err_b, buf_load_b}), 32'({1'b0, 1'b1}));

    // B: abort in the act_done cycle of layer 1
    found = 0;
    for (int i = 0; i < 60 && found == 0; i++) begin
      tick();
      if (act_start_b && cnn_layer_b == 3'd1) found = 1;
    end
    chk("b_found_act1", 32'(found), 32'd1);
    tick();
    abort_b = 1'b1;
    tick();
    abort_b = 1'b0;
    chk("b_abort_idle", 32'({busy_b, err_b, out_valid_b}), 32'd0);
    for (int i = 0; i < 4; i++) begin
      poke_b = (i == 0);
      tick();
      chk($sformatf("b_post_abort_%0d", i),
          32'({buf_load_b, cnn_start_b, act_start_b, comp_start_b, out_valid_b, busy_b}), 32'd0);
    end
    poke_b = 1'b0;
    start_b = 1'b1; abort_b = 1'b1;
    tick();
    start_b = 1'b0; abort_b = 1'b0;
    chk("b_abort_beats_start", 32'({busy_b, buf_load_b}), 32'd0);

    // C: no activation passes
    start_c = 1'b1;
    tick();
    start_c = 1'b0;
    lat = 1; act_seen = 0; lyr_cnt = 0;
    while (!out_valid_c && lat < 60) begin
      tick();
      lat++;
      if (act_start_c) act_seen++;
      if (cnn_start_c) begin
        chk($sformatf("c_layer_%0d", lyr_cnt), 32'({cnn_layer_c, cnn_src_sel_c}),
            32'({3'(lyr_cnt), (lyr_cnt == 0) ? 2'd0 : 2'd2}));
        lyr_cnt++;
      end
      if (comp_start_c) chk("c_comp_src", 32'(comp_src_sel_c), 32'd0);
    end
    chk("c_latency", 32'(lat), 32'd14);
    chk("c_no_act", 32'(act_seen), 32'd0);
    chk("c_layers", 32'(lyr_cnt), 32'd5);
    out_ready_c = 1'b1;
    tick();
    out_ready_c = 1'b0;
    chk("c_idle_class", 32'({busy_c, out_class_c}), 32'({1'b0, 4'd7}));

    // C: reset while in COMP
    start_c = 1'b1;
    tick();
    start_c = 1'b0;
    found = 0;
    for (int i = 0; i < 60 && found == 0; i++) begin
      if (comp_start_c) found = 1;
      else tick();
    end
    chk("c_found_comp", 32'(found), 32'd1);
    rst_c = 1'b1;
    tick();
    rst_c = 1'b0;
    chk("c_rst_outs", 32'({buf_load_c, cnn_start_c, act_start_c, comp_start_c, out_valid_c,
        busy_c, err_c, out_class_c, cnn_layer_c, cnn_src_sel_c}), 32'd0);
    tick();
    chk("c_rst_stay_idle", 32'({busy_c, out_valid_c}), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
